// File: rtl/bus_arbiter2.sv
// ---------------------------------------------------------------------------
// bus_arbiter2
//   Two-master arbiter in front of the single master port of the system BUS.
//   One master owns the bus at a time. Ties are broken round-robin using the
//   last-served pointer, and an owner that keeps requesting while the other
//   master waits is preempted after MAX_HOLD owned cycles (0 = never).
//
// Ports
//   clk, reset_n           rising-edge clock, asynchronous active-low reset
//   m0_* / m1_*            master request/write/address/write-data in,
//                          grant and read data out (owner only)
//   b_req/b_wr/b_addr/b_dout  routed copy of the owning master's request
//   b_grant/b_din          BUS grant and read data, returned to the owner
// ---------------------------------------------------------------------------
module bus_arbiter2 #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 64,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dout,
  output logic              m0_grant,
  output logic [DATA_W-1:0] m0_din,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m1_grant,
  output logic [DATA_W-1:0] m1_din,
  output logic              b_req,
  output logic              b_wr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_dout,
  input  logic              b_grant,
  input  logic [DATA_W-1:0] b_din
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  // The hold counter reads 0 in the first owned cycle, so the owner is
  // preempted while the counter shows MAX_HOLD-1, i.e. in its last allowed cycle.
  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

  logic [1:0] state_q, state_d;
  logic       lp_q, lp_d;     // last-served master
  logic [7:0] hc_q, hc_d;     // consecutive owned cycles minus one

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_req && m1_req) state_d = lp_q ? ST_OWN0 : ST_OWN1;
        else if (m0_req)      state_d = ST_OWN0;
        else if (m1_req)      state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (!m0_req)                                     state_d = m1_req ? ST_OWN1 : ST_IDLE;
        else if (m1_req && HOLD_EN && hc_q == HOLD_LAST) state_d = ST_OWN1;
      end
      ST_OWN1: begin
        if (!m1_req)                                     state_d = m0_req ? ST_OWN0 : ST_IDLE;
        else if (m0_req && HOLD_EN && hc_q == HOLD_LAST) state_d = ST_OWN0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lp_d = lp_q;
    if (state_d != state_q) begin
      if (state_d == ST_OWN0)      lp_d = 1'b0;
      else if (state_d == ST_OWN1) lp_d = 1'b1;
    end
  end

  always_comb begin
    hc_d = hc_q;
    if (state_d != state_q || state_q == ST_IDLE) hc_d = 8'd0;
    else if (hc_q != 8'hFF)                       hc_d = hc_q + 8'd1;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values; the reset branch is asynchronous and takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      lp_q    <= 1'b1;        // M0 wins the first tie after reset
      hc_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      lp_q    <= lp_d;
      hc_q    <= hc_d;
    end
  end

  // Output mux is purely combinational from the registered owner, so the
  // request reaches the BUS in the first owned cycle. Reset forces IDLE,
  // which zeroes every output without waiting for a clock.
  logic own0, own1;
  assign own0 = (state_q == ST_OWN0);
  assign own1 = (state_q == ST_OWN1);

  always_comb begin
    b_req  = 1'b0;
    b_wr   = 1'b0;
    b_addr = '0;
    b_dout = '0;
    if (own0) begin
      b_req  = m0_req;
      b_wr   = m0_wr;
      b_addr = m0_addr;
      b_dout = m0_dout;
    end else if (own1) begin
      b_req  = m1_req;
      b_wr   = m1_wr;
      b_addr = m1_addr;
      b_dout = m1_dout;
    end
  end

  assign m0_grant = own0 & b_grant;
  assign m1_grant = own1 & b_grant;
  assign m0_din   = own0 ? b_din : '0;
  assign m1_din   = own1 ? b_din : '0;

endmodule

// File: tb/tb_bus_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter2
//   Drives two arbiter instances (MAX_HOLD=8 and MAX_HOLD=0) from the same
//   masters and BUS. A driver pushes the reference model's expected outputs
//   for each cycle into a queue; a monitor pops and compares on the falling
//   edge. Directed phases cover the key scenarios, then random traffic.
// ---------------------------------------------------------------------------
module tb_bus_arbiter2;

  localparam int AW    = 16;
  localparam int DW    = 64;
  localparam int OUT_W = 1 + 1 + AW + DW + 1 + DW + 1 + DW;

  typedef logic [OUT_W-1:0] vec_t;
  typedef struct packed { vec_t h8; vec_t h0; } exp_t;

  // Reference model: owner -1 = nobody, else master index.
  typedef struct {
    int owner;
    int last;
    int held;
  } mstate_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0, b_grant = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_dout = '0, m1_dout = '0, b_din = '0;

  logic          h8_m0_grant, h8_m1_grant, h8_b_req, h8_b_wr;
  logic [DW-1:0] h8_m0_din, h8_m1_din, h8_b_dout;
  logic [AW-1:0] h8_b_addr;
  logic          h0_m0_grant, h0_m1_grant, h0_b_req, h0_b_wr;
  logic [DW-1:0] h0_m0_din, h0_m1_din, h0_b_dout;
  logic [AW-1:0] h0_b_addr;

  int checks = 0;
  int errors = 0;
  exp_t    sb_q[$];
  mstate_t ms[2];
  int      hold_lim[2] = '{8, 0};

  always #5 clk = ~clk;

  bus_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(8)) u_h8 (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m0_grant(h8_m0_grant), .m0_din(h8_m0_din),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m1_grant(h8_m1_grant), .m1_din(h8_m1_din),
    .b_req(h8_b_req), .b_wr(h8_b_wr), .b_addr(h8_b_addr), .b_dout(h8_b_dout),
    .b_grant(b_grant), .b_din(b_din)
  );

  bus_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(0)) u_h0 (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m0_grant(h0_m0_grant), .m0_din(h0_m0_din),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m1_grant(h0_m1_grant), .m1_din(h0_m1_din),
    .b_req(h0_b_req), .b_wr(h0_b_wr), .b_addr(h0_b_addr), .b_dout(h0_b_dout),
    .b_grant(b_grant), .b_din(b_din)
  );

  vec_t act_h8, act_h0;
  assign act_h8 = {h8_b_req, h8_b_wr, h8_b_addr, h8_b_dout,
                   h8_m0_grant, h8_m0_din, h8_m1_grant, h8_m1_din};
  assign act_h0 = {h0_b_req, h0_b_wr, h0_b_addr, h0_b_dout,
                   h0_m0_grant, h0_m0_din, h0_m1_grant, h0_m1_din};

  task automatic check(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expected outputs this cycle: the owner's request fields pass straight
  // through, and only the owner sees the BUS grant and read data.
  function automatic vec_t model_out(input mstate_t s);
    logic          req, wr, g0, g1;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout, d0, d1;
    req = 0; wr = 0; addr = '0; dout = '0; g0 = 0; g1 = 0; d0 = '0; d1 = '0;
    if (s.owner == 0) begin
      req = m0_req; wr = m0_wr; addr = m0_addr; dout = m0_dout;
      g0 = b_grant; d0 = b_din;
    end else if (s.owner == 1) begin
      req = m1_req; wr = m1_wr; addr = m1_addr; dout = m1_dout;
      g1 = b_grant; d1 = b_din;
    end
    return {req, wr, addr, dout, g0, d0, g1, d1};
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input int lim);
    mstate_t n;
    bit      r[2];
    int      nxt;
    r[0] = m0_req;
    r[1] = m1_req;
    nxt  = s.owner;
    if (s.owner < 0) begin
      if (r[0] && r[1]) nxt = 1 - s.last;
      else if (r[0])    nxt = 0;
      else if (r[1])    nxt = 1;
    end else begin
      int me    = s.owner;
      int other = 1 - s.owner;
      if (!r[me])                                    nxt = r[other] ? other : -1;
      else if (r[other] && lim != 0 && s.held == lim - 1) nxt = other;
    end
    n.owner = nxt;
    n.last  = (nxt >= 0 && nxt != s.owner) ? nxt : s.last;
    if (nxt != s.owner || nxt < 0) n.held = 0;
    else                           n.held = (s.held < 255) ? s.held + 1 : 255;
    return n;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) ms[d] = '{owner: -1, last: 1, held: 0};
  endtask

  task automatic push_and_step();
    exp_t e;
    e.h8 = model_out(ms[0]);
    e.h0 = model_out(ms[1]);
    sb_q.push_back(e);
    for (int d = 0; d < 2; d++) ms[d] = model_next(ms[d], hold_lim[d]);
  endtask

  task automatic rand_payload();
    m0_wr   = 1'($urandom_range(0, 1));
    m1_wr   = 1'($urandom_range(0, 1));
    m0_addr = AW'($urandom);
    m1_addr = AW'($urandom);
    m0_dout = {$urandom, $urandom};
    m1_dout = {$urandom, $urandom};
    b_grant = ($urandom_range(0, 3) != 0);
    b_din   = {$urandom, $urandom};
  endtask

  task automatic step(input bit r0, input bit r1);
    @(posedge clk);
    #1;
    m0_req = r0;
    m1_req = r1;
    rand_payload();
    push_and_step();
  endtask

  task automatic repeat_step(input bit r0, input bit r1, input int n);
    for (int i = 0; i < n; i++) step(r0, r1);
  endtask

  // Monitor: compare whatever the DUTs present against the queued expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("out_hold8", act_h8, e.h8);
      check("out_hold0", act_h0, e.h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2;
    check("reset_h8", act_h8, '0);
    check("reset_h0", act_h0, '0);
    #10;
    reset_n = 1'b1;

    // Tie from IDLE after reset goes to M0, then direct handoff to M1.
    repeat_step(1, 1, 4);
    repeat_step(0, 1, 3);
    repeat_step(0, 0, 2);

    // Single master request for four cycles.
    repeat_step(1, 0, 5);
    repeat_step(0, 0, 2);

    // M0 holds; M1 joins in the second owned cycle.
    repeat_step(1, 0, 2);
    repeat_step(1, 1, 14);
    repeat_step(0, 1, 3);
    repeat_step(0, 0, 2);

    // Both masters requesting continuously for 50 cycles.
    repeat_step(1, 1, 51);
    repeat_step(0, 0, 2);

    // Read through M1 with a fixed returned word.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      m0_req = 0;
      m1_req = 1;
      rand_payload();
      m1_wr   = 1'b0;
      m1_addr = 16'h0008;
      b_grant = 1'b1;
      b_din   = 64'hDEAD_BEEF_0000_0001;
      push_and_step();
    end
    repeat_step(0, 0, 2);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    repeat_step(0, 0, 2);

    // Reset pulse while M1 owns the bus.
    repeat_step(0, 1, 3);
    @(posedge clk);
    #1;
    m0_req = 0;
    m1_req = 1;
    rand_payload();
    b_grant = 1'b1;
    push_and_step();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_h8", act_h8, '0);
    check("async_reset_h0", act_h0, '0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m0_req  = 1;
    m1_req  = 1;
    rand_payload();
    push_and_step();
    repeat_step(1, 1, 3);
    repeat_step(0, 0, 2);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
